// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: R-type/ECALL encodings, ALU operation codes and the
// fetch/decode FSM state type. The ALU imports the same operation codes.
package riscv_pkg;

  localparam logic [6:0]  OP_RTYPE    = 7'b0110011;
  localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  localparam logic [6:0] ALU_ADD  = 7'h00;
  localparam logic [6:0] ALU_SLL  = 7'h01;
  localparam logic [6:0] ALU_SLT  = 7'h02;
  localparam logic [6:0] ALU_SLTU = 7'h03;
  localparam logic [6:0] ALU_XOR  = 7'h04;
  localparam logic [6:0] ALU_SRL  = 7'h05;
  localparam logic [6:0] ALU_OR   = 7'h06;
  localparam logic [6:0] ALU_AND  = 7'h07;
  localparam logic [6:0] ALU_SUB  = 7'h08;
  localparam logic [6:0] ALU_SRA  = 7'h0D;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } fd_state_t;

  // ALU code is the alternate-encoding bit of funct7 above funct3.
  function automatic logic [6:0] alu_op(input logic funct7_b5, input logic [2:0] funct3);
    return {3'b000, funct7_b5, funct3};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational R-type decoder: register offsets, ALU operation code and
// legal / ECALL classification of a 32-bit instruction word.
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rw,
  output logic [6:0]  operation,
  output logic        legal,
  output logic        is_ecall
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Field extraction and legality check; alternate funct7 only allows SUB and SRA.
  always_comb begin
    rs1       = instr[19:15];
    rs2       = instr[24:20];
    rw        = instr[11:7];
    operation = alu_op(instr[30], funct3);
    is_ecall  = (instr == ECALL_INSTR);
    legal     = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct7)
        FUNCT7_BASE: legal = 1'b1;
        FUNCT7_ALT:  legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        default:     legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode stage: holds the PC, fetches one instruction at a
// time over a req/valid handshake, decodes R-type ops for the datapath and
// halts on ECALL.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for run after reset
// FETCH   | imem_req high at PC until imem_valid, then latch instruction
// DECODE  | register rs1/rs2/rw/operation and classify the instruction
// EXECUTE | one cycle: write/illegal strobe, retire count, advance PC
// HALT    | ECALL retired; terminal until reset
module fetch_decode
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rw,
  output logic [6:0]  operation,
  output logic        write,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instr_count
);

  fd_state_t   state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        legal_q;
  logic        ecall_q;

  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rw;
  logic [6:0]  dec_operation;
  logic        dec_legal;
  logic        dec_is_ecall;

  instr_decoder u_instr_decoder (
    .instr     (ir),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rw        (dec_rw),
    .operation (dec_operation),
    .legal     (dec_legal),
    .is_ecall  (dec_is_ecall)
  );

  assign imem_addr = pc;

  // Sequencer: all outputs are registered so write/illegal land exactly on EXECUTE
  // and the decoded fields stay frozen until the next DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      legal_q     <= 1'b0;
      ecall_q     <= 1'b0;
      imem_req    <= 1'b0;
      rs1         <= '0;
      rs2         <= '0;
      rw          <= '0;
      operation   <= '0;
      write       <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          rs1       <= dec_rs1;
          rs2       <= dec_rs2;
          rw        <= dec_rw;
          operation <= dec_operation;
          legal_q   <= dec_legal;
          ecall_q   <= dec_is_ecall;
          // x0 writes are suppressed but the instruction still retires
          write     <= dec_legal && (dec_rw != 5'd0);
          illegal   <= !dec_legal && !dec_is_ecall;
          state     <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          write   <= 1'b0;
          illegal <= 1'b0;
          if (legal_q || ecall_q) begin
            instr_count <= instr_count + 32'd1;
          end
          if (ecall_q) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            pc       <= pc + 32'd4;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_HALT: begin
          imem_req <= 1'b0;
          write    <= 1'b0;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: a memory driver issues instructions and
// pushes the reference outcome; a monitor follows the handshake timing and
// checks the EXECUTE cycle and the cycle after it.
module tb_fetch_decode;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rw;
    logic [6:0]  op;
    logic        wr;
    logic        ill;
    logic [31:0] cnt;
    logic [31:0] next_addr;
    logic        hlt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [4:0]  rs1, rs2, rw;
  logic [6:0]  operation;
  logic        write, halted, illegal;
  logic [31:0] instr_count;

  logic        reset2 = 1'b1;
  logic        run2 = 1'b0;
  logic        imem_valid2 = 1'b0;
  logic [31:0] imem_rdata2 = '0;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [4:0]  rs1_2, rs2_2, rw_2;
  logic [6:0]  operation2;
  logic        write2, halted2, illegal2;
  logic [31:0] instr_count2;

  int vectors = 0;
  int errors  = 0;
  int stage   = 0;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_halted;

  always #5 clk = ~clk;

  fetch_decode dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rs1(rs1), .rs2(rs2), .rw(rw), .operation(operation),
    .write(write), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset2), .run(run2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid2), .imem_rdata(imem_rdata2),
    .rs1(rs1_2), .rs2(rs2_2), .rw(rw_2), .operation(operation2),
    .write(write2), .halted(halted2), .illegal(illegal2), .instr_count(instr_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the set of legal {funct7,funct3} pairs and their ALU names.
  task automatic model(input logic [31:0] w, output exp_t e);
    logic [9:0] key;
    logic       rt, ec;
    logic [6:0] op_name;
    key = {w[31:25], w[14:12]};
    rt = 1'b0;
    op_name = 7'h7F;
    if (w[6:0] == 7'h33) begin
      case (key)
        10'h000: begin rt = 1; op_name = 7'h00; end  // ADD
        10'h001: begin rt = 1; op_name = 7'h01; end  // SLL
        10'h002: begin rt = 1; op_name = 7'h02; end  // SLT
        10'h003: begin rt = 1; op_name = 7'h03; end  // SLTU
        10'h004: begin rt = 1; op_name = 7'h04; end  // XOR
        10'h005: begin rt = 1; op_name = 7'h05; end  // SRL
        10'h006: begin rt = 1; op_name = 7'h06; end  // OR
        10'h007: begin rt = 1; op_name = 7'h07; end  // AND
        10'h100: begin rt = 1; op_name = 7'h08; end  // SUB
        10'h105: begin rt = 1; op_name = 7'h0D; end  // SRA
        default: rt = 0;
      endcase
    end
    ec = (w == 32'h0000_0073);
    e.pc  = m_pc;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rw  = w[11:7];
    e.op  = rt ? op_name : {3'b000, w[30], w[14:12]};
    e.wr  = rt && (w[11:7] != 5'd0);
    e.ill = !rt && !ec;
    if (rt || ec) m_cnt = m_cnt + 1;
    e.cnt = m_cnt;
    if (ec) m_halted = 1'b1;
    else    m_pc = m_pc + 32'd4;
    e.next_addr = m_pc;
    e.hlt = m_halted;
  endtask

  task automatic wait_req(output bit got);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (imem_req) begin
        got = 1;
        return;
      end
      step();
    end
    errors++;
    $display("FAIL fetch_timeout actual=req_low expected=req_high");
  endtask

  task automatic issue(input logic [31:0] w, input int waits);
    exp_t e;
    bit   got;
    wait_req(got);
    if (!got) return;
    chk("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      imem_rdata = $urandom;
      step();
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, m_pc);
    end
    model(w, e);
    sb.push_back(e);
    imem_valid = 1'b1;
    imem_rdata = w;
    step();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0 && stage == 0) return;
      step();
    end
    errors++;
    $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_fields"}, {10'd0, rs1, rs2, rw, operation}, 32'd0);
    chk({tag, "_flags"}, {29'd0, write, halted, illegal}, 32'd0);
    chk({tag, "_count"}, instr_count, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check_reset_values("reset");
    m_pc = 32'd0;
    m_cnt = 32'd0;
    m_halted = 1'b0;
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic rand_instr(output logic [31:0] w);
    int kind;
    logic [9:0] legal_keys [10];
    logic [9:0] k;
    logic [2:0] f3;
    logic [6:0] f7;
    legal_keys = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h004,
                   10'h005, 10'h006, 10'h007, 10'h100, 10'h105};
    w = $urandom;
    kind = $urandom_range(0, 9);
    if (kind <= 6) begin
      k = legal_keys[$urandom_range(0, 9)];
      w[31:25] = k[9:3];
      w[14:12] = k[2:0];
      w[6:0] = 7'h33;
      if (kind == 6) w[11:7] = 5'd0;
    end else if (kind == 7) begin
      do f3 = 3'($urandom_range(0, 7)); while (f3 == 3'd0 || f3 == 3'd5);
      w[31:25] = 7'h20;
      w[14:12] = f3;
      w[6:0] = 7'h33;
    end else if (kind == 8) begin
      do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
      w[31:25] = f7;
      w[6:0] = 7'h33;
    end else begin
      if (w[6:0] == 7'h33) w[6:0] = 7'h13;
      if (w == 32'h0000_0073) w = 32'h0000_0173;
    end
  endtask

  // Monitor: handshake seen -> DECODE -> EXECUTE (sample) -> next cycle (check).
  logic [31:0] cap_pc;
  logic [4:0]  cap_rs1, cap_rs2, cap_rw;
  logic [6:0]  cap_op;
  logic        cap_wr, cap_ill;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stage = 0;
        continue;
      end
      if (stage != 2 && (write || illegal)) begin
        errors++;
        $display("FAIL stray_pulse actual=write:%0b,illegal:%0b expected=0,0", write, illegal);
      end
      case (stage)
        1: stage = 2;
        2: begin
          cap_pc = imem_addr;
          cap_rs1 = rs1; cap_rs2 = rs2; cap_rw = rw; cap_op = operation;
          cap_wr = write; cap_ill = illegal;
          stage = 3;
        end
        3: begin
          stage = 0;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_exec actual=retire expected=none");
          end else begin
            e = sb.pop_front();
            chk("exec_pc", cap_pc, e.pc);
            chk("rs1", {27'd0, cap_rs1}, {27'd0, e.rs1});
            chk("rs2", {27'd0, cap_rs2}, {27'd0, e.rs2});
            chk("rw", {27'd0, cap_rw}, {27'd0, e.rw});
            chk("operation", {25'd0, cap_op}, {25'd0, e.op});
            chk("write", {31'd0, cap_wr}, {31'd0, e.wr});
            chk("illegal", {31'd0, cap_ill}, {31'd0, e.ill});
            chk("instr_count", instr_count, e.cnt);
            chk("next_addr", imem_addr, e.next_addr);
            chk("halted", {31'd0, halted}, {31'd0, e.hlt});
            chk("req_after_exec", {31'd0, imem_req}, {31'd0, !e.hlt});
          end
        end
        default: ;
      endcase
      if (stage == 0 && imem_req && imem_valid) stage = 1;
    end
  end

  initial begin
    logic [31:0] w;
    bit got;
    m_pc = 0; m_cnt = 0; m_halted = 0;

    do_reset();
    run = 1'b1;
    step();
    chk("idle_to_fetch_req", {31'd0, imem_req}, 32'd1);
    issue(32'h002081B3, 0);             // ADD x3,x1,x2
    drain();

    do_reset();
    issue(32'h407302B3, 4);             // SUB x5,x6,x7, four wait cycles
    issue(32'h00208033, 0);             // ADD x0,x1,x2
    issue(32'h00100093, 1);             // ADDI: illegal
    drain();

    for (int n = 0; n < 80; n++) begin
      rand_instr(w);
      issue(w, $urandom_range(0, 3));
    end
    issue(32'h0000_0073, 2);            // ECALL
    drain();
    for (int i = 0; i < 12; i++) begin
      step();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_sticky", {31'd0, halted}, 32'd1);
    end

    // reset mid-FETCH, then a late imem_valid
    do_reset();
    wait_req(got);
    step();
    run = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_pc = 0; m_cnt = 0; m_halted = 0;
    sb.delete();
    imem_valid = 1'b1;
    imem_rdata = 32'h002081B3;
    step();
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_reset_values("post_abort");
      step();
    end

    // PC wrap with RESET_PC = FFFF_FFFC
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    run2 = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (imem_req2) got = 1; else step();
    end
    chk("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
    imem_valid2 = 1'b1;
    imem_rdata2 = 32'h002081B3;
    step();
    imem_valid2 = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (imem_req2) got = 1;
    end
    chk("wrap_second_req", {31'd0, imem_req2}, 32'd1);
    chk("wrap_second_addr", imem_addr2, 32'h0000_0000);
    chk("wrap_count", instr_count2, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
